// File: rtl/card_dealer_if.sv
// Dealer-side bundle: seed/shuffle/draw requests in, dealt card and deck status out.
interface card_dealer_if #(
    parameter int SEED_WIDTH = 12
);
    logic [SEED_WIDTH-1:0] i_Seed;
    logic                  i_Shuffle;
    logic                  i_Draw;
    logic                  o_Ready;
    logic                  o_Valid;
    logic [5:0]            o_Card;
    logic [1:0]            o_Suit;
    logic [3:0]            o_Rank;
    logic [3:0]            o_Points;
    logic [5:0]            o_Remaining;
    logic                  o_Empty;

    modport master (
        output i_Seed, i_Shuffle, i_Draw,
        input  o_Ready, o_Valid, o_Card, o_Suit, o_Rank, o_Points, o_Remaining, o_Empty
    );

    modport slave (
        input  i_Seed, i_Shuffle, i_Draw,
        output o_Ready, o_Valid, o_Card, o_Suit, o_Rank, o_Points, o_Remaining, o_Empty
    );
endinterface

// File: rtl/card_dealer.sv
// card_dealer: deals a 52-card deck without repetition, start index from a seeded 12-bit LFSR.
// Build macro DEALER_TEST_SEQ_EN swaps the LFSR start index for a sequential pointer (deals 0,1,2,...).
//
// state  | meaning
// IDLE   | o_Ready high, waiting for a draw
// SEARCH | probing one deck index per cycle for an unused card
// DONE   | o_Valid pulse, card outputs just updated
module card_dealer #(
    parameter int SEED_WIDTH = 12,
    parameter int DECK_SIZE  = 52
) (
    input logic          clk_50M,
    input logic          i_Reset_n,
    card_dealer_if.slave bus
);
    localparam logic [5:0]            DECK_CNT  = 6'(DECK_SIZE);
    localparam logic [5:0]            LAST_IDX  = 6'(DECK_SIZE - 1);
    localparam logic [SEED_WIDTH-1:0] LFSR_INIT = SEED_WIDTH'(12'h001);
    localparam logic [SEED_WIDTH-1:0] LFSR_ALT  = SEED_WIDTH'(12'hACE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state;
    logic [SEED_WIDTH-1:0] lfsr;
    logic [DECK_SIZE-1:0]  used_mask;
    logic [5:0]            idx;
    logic                  ready_q;
    logic                  valid_q;
    logic [5:0]            card_q;
    logic [1:0]            suit_q;
    logic [3:0]            rank_q;
    logic [3:0]            points_q;
    logic [5:0]            remaining_q;
    logic                  empty_q;

    logic                  lfsr_fb;
    logic [SEED_WIDTH-1:0] lfsr_next;
    logic [SEED_WIDTH-1:0] seed_load;
    logic [5:0]            start_idx;
    logic [5:0]            idx_next;
    logic [5:0]            suit_base;
    logic [1:0]            card_suit;
    logic [3:0]            card_rank;
    logic [3:0]            card_points;

    assign lfsr_fb   = lfsr[11] ^ lfsr[10] ^ lfsr[9] ^ lfsr[3];
    assign lfsr_next = {lfsr[SEED_WIDTH-2:0], lfsr_fb};
    // An all-zero LFSR would lock up, so a zero seed is replaced.
    assign seed_load = (bus.i_Seed == '0) ? LFSR_ALT : bus.i_Seed;
    assign idx_next  = (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;

`ifdef DEALER_TEST_SEQ_EN
    logic [5:0] seq_ptr;
    logic [5:0] seq_ptr_next;

    assign start_idx    = seq_ptr;
    assign seq_ptr_next = (seq_ptr == LAST_IDX) ? 6'd0 : seq_ptr + 6'd1;
`else
    logic [5:0] lfsr_idx;

    assign lfsr_idx  = lfsr[5:0];
    assign start_idx = (lfsr_idx >= DECK_CNT) ? lfsr_idx - DECK_CNT : lfsr_idx;
`endif

    always_comb begin
        card_suit = 2'd0;
        suit_base = 6'd0;
        if (idx >= 6'd39) begin
            card_suit = 2'd3;
            suit_base = 6'd39;
        end else if (idx >= 6'd26) begin
            card_suit = 2'd2;
            suit_base = 6'd26;
        end else if (idx >= 6'd13) begin
            card_suit = 2'd1;
            suit_base = 6'd13;
        end
        card_rank   = 4'(idx - suit_base + 6'd1);
        card_points = (card_rank > 4'd10) ? 4'd10 : card_rank;
    end

    always_ff @(posedge clk_50M) begin
        if (!i_Reset_n) begin
            state       <= IDLE;
            lfsr        <= LFSR_INIT;
            used_mask   <= '0;
            idx         <= 6'd0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            card_q      <= 6'd0;
            suit_q      <= 2'd0;
            rank_q      <= 4'd0;
            points_q    <= 4'd0;
            remaining_q <= DECK_CNT;
            empty_q     <= 1'b0;
`ifdef DEALER_TEST_SEQ_EN
            seq_ptr     <= 6'd0;
`endif
        end else begin
            lfsr <= lfsr_next;
            if (bus.i_Shuffle) begin
                // Shuffle overrides everything: pending search and same-cycle draw are dropped.
                lfsr        <= seed_load;
                used_mask   <= '0;
                remaining_q <= DECK_CNT;
                empty_q     <= 1'b0;
                state       <= IDLE;
                ready_q     <= 1'b1;
                valid_q     <= 1'b0;
`ifdef DEALER_TEST_SEQ_EN
                seq_ptr     <= 6'd0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        valid_q <= 1'b0;
                        if (bus.i_Draw && !empty_q) begin
                            idx     <= start_idx;
                            state   <= SEARCH;
                            ready_q <= 1'b0;
                        end
                    end
                    SEARCH: begin
                        if (!used_mask[idx]) begin
                            used_mask[idx] <= 1'b1;
                            card_q         <= idx;
                            suit_q         <= card_suit;
                            rank_q         <= card_rank;
                            points_q       <= card_points;
                            remaining_q    <= remaining_q - 6'd1;
                            empty_q        <= (remaining_q == 6'd1);
                            valid_q        <= 1'b1;
                            state          <= DONE;
`ifdef DEALER_TEST_SEQ_EN
                            seq_ptr        <= seq_ptr_next;
`endif
                        end else begin
                            idx <= idx_next;
                        end
                    end
                    DONE: begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                    default: begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_Ready     = ready_q;
    assign bus.o_Valid     = valid_q;
    assign bus.o_Card      = card_q;
    assign bus.o_Suit      = suit_q;
    assign bus.o_Rank      = rank_q;
    assign bus.o_Points    = points_q;
    assign bus.o_Remaining = remaining_q;
    assign bus.o_Empty     = empty_q;
endmodule
